// File: rtl/ram_1r1w_sync_mc_pkg.sv
// Shared types and helpers for the multi-lane 1R1W RAM and its clear sequencer.
package ram_mc_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } ram_state_e;

  localparam int lane_max_lp = 64;
  localparam int data_max_lp = 1024;

  // Lane k of a word whose lanes are w bits wide; caller zero-extends in and truncates out.
  function automatic logic [lane_max_lp-1:0] lane_slice(input logic [data_max_lp-1:0] data,
                                                         input int k, input int w);
    return lane_max_lp'(data >> (k * w));
  endfunction

endpackage

// File: rtl/ram_1r1w_sync_mc_if.sv
// Request/response bundle of the multi-lane RAM; slave = RAM, master = user.
interface ram_1r1w_sync_mc_if
  import ram_mc_pkg::*;
#(
  parameter int width_p    = 8,
  parameter int channels_p = 3,
  parameter int depth_p    = 512
);
  localparam int addr_w_lp = $clog2(depth_p);
  localparam int data_w_lp = channels_p * width_p;

  // Requests are single-cycle valid pulses with no ready: while busy_o is high they are
  // dropped; otherwise each rd_valid_i yields exactly one rd_valid_o pulse after the read latency.
  logic                   wr_valid_i;
  logic [channels_p-1:0]  wr_mask_i;
  logic [addr_w_lp-1:0]   wr_addr_i;
  logic [data_w_lp-1:0]   wr_data_i;
  logic                   rd_valid_i;
  logic [addr_w_lp-1:0]   rd_addr_i;
  logic [data_w_lp-1:0]   rd_data_o;
  logic                   rd_valid_o;
  logic                   busy_o;
  ram_state_e             dbg_state;

  modport master (
    output wr_valid_i, wr_mask_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i,
    input  rd_data_o, rd_valid_o, busy_o, dbg_state
  );

  modport slave (
    input  wr_valid_i, wr_mask_i, wr_addr_i, wr_data_i, rd_valid_i, rd_addr_i,
    output rd_data_o, rd_valid_o, busy_o, dbg_state
  );

endinterface

// File: rtl/ram_1r1w_sync_mc_clear_seq.sv
// Post-reset clear sequencer: walks every address once, then parks in RUN until reset.
module ram_clear_seq
  import ram_mc_pkg::*;
#(
  parameter int depth_p = 512,
  parameter bit clear_p = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  output logic                       clr_we,
  output logic [$clog2(depth_p)-1:0] clr_addr,
  output logic                       busy,
  output ram_state_e                 state
);

  localparam int                aw_lp          = $clog2(depth_p);
  localparam logic [aw_lp-1:0]  last_lp        = aw_lp'(depth_p - 1);
  localparam ram_state_e        reset_state_lp = clear_p ? CLEAR : RUN;

  ram_state_e       state_n;
  logic [aw_lp-1:0] cnt_q, cnt_n;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= reset_state_lp;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      cnt_q <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    case (state)
      CLEAR: begin
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == last_lp) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN:     state_n = RUN;
      default: state_n = reset_state_lp;
    endcase
  end

  always_comb begin
    clr_we   = (state == CLEAR);
    busy     = (state == CLEAR);
    clr_addr = cnt_q;
  end

endmodule

// File: rtl/ram_1r1w_sync_mc.sv
// Multi-lane 1R1W synchronous RAM with per-lane write mask, optional bypass,
// optional output register and a post-reset fill sequence.
module ram_1r1w_sync_mc
  import ram_mc_pkg::*;
#(
  parameter int                 width_p    = 8,
  parameter int                 channels_p = 3,
  parameter int                 depth_p    = 512,
  parameter bit                 bypass_p   = 1'b1,
  parameter bit                 out_reg_p  = 1'b0,
  parameter bit                 clear_p    = 1'b1,
  parameter logic [width_p-1:0] fill_p     = '0
) (
  input logic              clk_i,
  input logic              reset_ni,
  ram_1r1w_sync_mc_if.slave bus
);

  localparam int               aw_lp    = $clog2(depth_p);
  localparam int               dw_lp    = channels_p * width_p;
  localparam logic [aw_lp:0]   depth_lp = (aw_lp + 1)'(depth_p);

  ram_state_e        state;
  logic              busy, run, clr_we;
  logic [aw_lp-1:0]  clr_addr;

  ram_clear_seq #(.depth_p(depth_p), .clear_p(clear_p)) u_clear_seq (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy),
    .state    (state)
  );

  assign run = ~busy;

  // Non-power-of-two depths leave a hole at the top of the address space.
  logic wr_in_range, rd_in_range, user_we, collide;
  assign wr_in_range = {1'b0, bus.wr_addr_i} < depth_lp;
  assign rd_in_range = {1'b0, bus.rd_addr_i} < depth_lp;
  assign user_we     = run & bus.wr_valid_i & wr_in_range;
  assign collide     = bypass_p & user_we & (bus.wr_addr_i == bus.rd_addr_i);

  logic                  mem_we;
  logic [aw_lp-1:0]      mem_addr;
  logic [channels_p-1:0] mem_mask;
  logic [dw_lp-1:0]      mem_wdata;

  always_comb begin
    mem_we    = clr_we | user_we;
    mem_addr  = clr_we ? clr_addr : bus.wr_addr_i;
    mem_mask  = clr_we ? {channels_p{1'b1}} : bus.wr_mask_i;
    mem_wdata = clr_we ? {channels_p{fill_p}} : bus.wr_data_i;
  end

  logic [dw_lp-1:0] mem [depth_p];

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int k = 0; k < channels_p; k++) begin
        if (mem_mask[k]) mem[mem_addr][k*width_p +: width_p] <= mem_wdata[k*width_p +: width_p];
      end
    end
  end

  logic [dw_lp-1:0]   rd_raw, rd_merge, rd_word;
  logic [width_p-1:0] wr_lane, raw_lane;

  always_comb begin
    rd_raw   = mem[bus.rd_addr_i];
    rd_merge = '0;
    wr_lane  = '0;
    raw_lane = '0;
    for (int k = 0; k < channels_p; k++) begin
      wr_lane  = width_p'(lane_slice(data_max_lp'(bus.wr_data_i), k, width_p));
      raw_lane = width_p'(lane_slice(data_max_lp'(rd_raw), k, width_p));
      rd_merge[k*width_p +: width_p] = (collide && bus.wr_mask_i[k]) ? wr_lane : raw_lane;
    end
    rd_word = rd_in_range ? rd_merge : '0;
  end

  logic             s1_vld;
  logic [dw_lp-1:0] s1_data;

  // Data register only loads on a real result so the output holds between reads.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= run & bus.rd_valid_i;
      if (run && bus.rd_valid_i) s1_data <= rd_word;
    end
  end

  generate
    if (out_reg_p) begin : g_out_reg
      logic             s2_vld;
      logic [dw_lp-1:0] s2_data;
      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          s2_vld  <= 1'b0;
          s2_data <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) s2_data <= s1_data;
        end
      end
      assign bus.rd_valid_o = s2_vld;
      assign bus.rd_data_o  = s2_data;
    end else begin : g_no_out_reg
      assign bus.rd_valid_o = s1_vld;
      assign bus.rd_data_o  = s1_data;
    end
  endgenerate

  assign bus.busy_o    = busy;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_ram_1r1w_sync_mc.sv
// Directed bench: four RAM configurations driven by one shared stimulus stream.
module tb_ram_1r1w_sync_mc;
  import ram_mc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        wr_valid, rd_valid;
  logic [2:0]  wr_mask;
  logic [3:0]  wr_addr, rd_addr;
  logic [23:0] wr_data;

  int tests = 0;
  int fails = 0;
  logic saw_vld;
  int na, nb, nc, nd;
  logic [23:0] exp_d [12];

  // a: bypass, fill A5 | b: no bypass | c: output register | d: depth 12
  ram_1r1w_sync_mc_if #(.width_p(8), .channels_p(3), .depth_p(16)) if_a(), if_b(), if_c();
  ram_1r1w_sync_mc_if #(.width_p(8), .channels_p(3), .depth_p(12)) if_d();

  assign if_a.wr_valid_i = wr_valid; assign if_a.wr_mask_i = wr_mask; assign if_a.wr_addr_i = wr_addr;
  assign if_a.wr_data_i  = wr_data;  assign if_a.rd_valid_i = rd_valid; assign if_a.rd_addr_i = rd_addr;
  assign if_b.wr_valid_i = wr_valid; assign if_b.wr_mask_i = wr_mask; assign if_b.wr_addr_i = wr_addr;
  assign if_b.wr_data_i  = wr_data;  assign if_b.rd_valid_i = rd_valid; assign if_b.rd_addr_i = rd_addr;
  assign if_c.wr_valid_i = wr_valid; assign if_c.wr_mask_i = wr_mask; assign if_c.wr_addr_i = wr_addr;
  assign if_c.wr_data_i  = wr_data;  assign if_c.rd_valid_i = rd_valid; assign if_c.rd_addr_i = rd_addr;
  assign if_d.wr_valid_i = wr_valid; assign if_d.wr_mask_i = wr_mask; assign if_d.wr_addr_i = wr_addr;
  assign if_d.wr_data_i  = wr_data;  assign if_d.rd_valid_i = rd_valid; assign if_d.rd_addr_i = rd_addr;

  ram_1r1w_sync_mc #(.width_p(8), .channels_p(3), .depth_p(16), .bypass_p(1'b1), .out_reg_p(1'b0),
                     .clear_p(1'b1), .fill_p(8'hA5)) dut_a (.clk_i(clk), .reset_ni(reset_n), .bus(if_a.slave));
  ram_1r1w_sync_mc #(.width_p(8), .channels_p(3), .depth_p(16), .bypass_p(1'b0), .out_reg_p(1'b0),
                     .clear_p(1'b1), .fill_p(8'h00)) dut_b (.clk_i(clk), .reset_ni(reset_n), .bus(if_b.slave));
  ram_1r1w_sync_mc #(.width_p(8), .channels_p(3), .depth_p(16), .bypass_p(1'b1), .out_reg_p(1'b1),
                     .clear_p(1'b1), .fill_p(8'h00)) dut_c (.clk_i(clk), .reset_ni(reset_n), .bus(if_c.slave));
  ram_1r1w_sync_mc #(.width_p(8), .channels_p(3), .depth_p(12), .bypass_p(1'b1), .out_reg_p(1'b0),
                     .clear_p(1'b1), .fill_p(8'h00)) dut_d (.clk_i(clk), .reset_ni(reset_n), .bus(if_d.slave));

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  // ---------------- checkers ----------------
  task automatic chk_d(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Records, per instance, the first cycle after release at which busy_o is low.
  task automatic count_busy();
    na = 0; nb = 0; nc = 0; nd = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (na == 0 && !if_a.busy_o) na = i;
      if (nb == 0 && !if_b.busy_o) nb = i;
      if (nc == 0 && !if_c.busy_o) nc = i;
      if (nd == 0 && !if_d.busy_o) nd = i;
      saw_vld = saw_vld | if_a.rd_valid_o | if_b.rd_valid_o | if_c.rd_valid_o | if_d.rd_valid_o;
      if (i == 10) idle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0;
    idle();
    wr_mask = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (2) tick();
    chk_b("rst_busy_a", if_a.busy_o, 1'b1);
    chk_b("rst_busy_d", if_d.busy_o, 1'b1);
    chk_b("rst_vld_a", if_a.rd_valid_o, 1'b0);
    chk_b("rst_vld_c", if_c.rd_valid_o, 1'b0);
    chk_d("rst_data_a", if_a.rd_data_o, 24'h0);
    chk_b("rst_state_a", if_a.dbg_state, CLEAR);

    // Requests held through most of the clear must all be ignored.
    wr_valid = 1'b1; wr_mask = 3'b111; wr_addr = 4'd2; wr_data = 24'h123456;
    rd_valid = 1'b1; rd_addr = 4'd2;
    saw_vld = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    count_busy();
    chk_i("busy_len_a", na, 16);
    chk_i("busy_len_b", nb, 16);
    chk_i("busy_len_c", nc, 16);
    chk_i("busy_len_d", nd, 12);
    chk_b("clear_no_vld", saw_vld, 1'b0);
    chk_b("state_run_a", if_a.dbg_state, RUN);

    // Read back the whole array, one request per cycle.
    for (int i = 0; i < 16; i++) begin
      rd_valid = 1'b1; rd_addr = i[3:0];
      tick();
      chk_b($sformatf("fill_vld_a%0d", i), if_a.rd_valid_o, 1'b1);
      chk_d($sformatf("fill_a%0d", i), if_a.rd_data_o, 24'hA5A5A5);
      chk_d($sformatf("fill_b%0d", i), if_b.rd_data_o, 24'h000000);
      chk_b($sformatf("fill_vld_d%0d", i), if_d.rd_valid_o, 1'b1);
      chk_d($sformatf("fill_d%0d", i), if_d.rd_data_o, 24'h000000);
      if (i > 0) chk_b($sformatf("fill_vld_c%0d", i), if_c.rd_valid_o, 1'b1);
    end
    idle();
    tick();
    chk_b("fill_tail_vld_c", if_c.rd_valid_o, 1'b1);
    chk_b("fill_tail_vld_a", if_a.rd_valid_o, 1'b0);
    chk_d("fill_hold_a", if_a.rd_data_o, 24'hA5A5A5);
    tick();
    chk_b("fill_end_vld_c", if_c.rd_valid_o, 1'b0);

    // Masked write to addr 3, lanes 0 and 2.
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 24'h112233; wr_mask = 3'b101;
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd3;
    tick();
    rd_valid = 1'b0;
    chk_d("mask_a", if_a.rd_data_o, 24'h11A533);
    chk_d("mask_b", if_b.rd_data_o, 24'h110033);
    chk_d("mask_d", if_d.rd_data_o, 24'h110033);
    chk_b("mask_vld_c_early", if_c.rd_valid_o, 1'b0);
    tick();
    chk_b("mask_vld_c", if_c.rd_valid_o, 1'b1);
    chk_d("mask_c", if_c.rd_data_o, 24'h110033);
    chk_b("mask_vld_a_pulse", if_a.rd_valid_o, 1'b0);

    // Same-cycle read/write at addr 5, lanes 0 and 1.
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 24'hFFFFFF; wr_mask = 3'b011;
    rd_valid = 1'b1; rd_addr = 4'd5;
    tick();
    wr_valid = 1'b0;
    chk_d("coll_byp_a", if_a.rd_data_o, 24'hA5FFFF);
    chk_d("coll_nobyp_b", if_b.rd_data_o, 24'h000000);
    chk_d("coll_byp_d", if_d.rd_data_o, 24'h00FFFF);
    tick();
    rd_valid = 1'b0;
    chk_d("coll_after_a", if_a.rd_data_o, 24'hA5FFFF);
    chk_d("coll_after_b", if_b.rd_data_o, 24'h00FFFF);
    chk_d("coll_byp_c", if_c.rd_data_o, 24'h00FFFF);
    tick();
    chk_d("coll_after_c", if_c.rd_data_o, 24'h00FFFF);
    chk_b("coll_vld_c", if_c.rd_valid_o, 1'b1);
    tick();
    chk_b("coll_end_vld_c", if_c.rd_valid_o, 1'b0);

    // Output-register latency: reads of 1,2,3 back to back.
    wr_valid = 1'b1; wr_mask = 3'b111; wr_addr = 4'd1; wr_data = 24'h0A0B0C;
    tick();
    wr_addr = 4'd2; wr_data = 24'h102030;
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd1;
    tick();
    chk_b("oreg_n1_vld_c", if_c.rd_valid_o, 1'b0);
    chk_d("oreg_n1_a", if_a.rd_data_o, 24'h0A0B0C);
    rd_addr = 4'd2;
    tick();
    chk_b("oreg_n2_vld_c", if_c.rd_valid_o, 1'b1);
    chk_d("oreg_n2_c", if_c.rd_data_o, 24'h0A0B0C);
    rd_addr = 4'd3;
    tick();
    rd_valid = 1'b0;
    chk_b("oreg_n3_vld_c", if_c.rd_valid_o, 1'b1);
    chk_d("oreg_n3_c", if_c.rd_data_o, 24'h102030);
    tick();
    chk_b("oreg_n4_vld_c", if_c.rd_valid_o, 1'b1);
    chk_d("oreg_n4_c", if_c.rd_data_o, 24'h110033);
    tick();
    chk_b("oreg_n5_vld_c", if_c.rd_valid_o, 1'b0);
    chk_d("oreg_hold_c", if_c.rd_data_o, 24'h110033);

    // Out-of-range on the 12-deep instance.
    wr_valid = 1'b1; wr_mask = 3'b111; wr_addr = 4'd13; wr_data = 24'h777777;
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd13;
    tick();
    rd_valid = 1'b0;
    chk_b("oor_vld_d", if_d.rd_valid_o, 1'b1);
    chk_d("oor_data_d", if_d.rd_data_o, 24'h000000);
    chk_d("inrange_a13", if_a.rd_data_o, 24'h777777);
    foreach (exp_d[i]) exp_d[i] = 24'h0;
    exp_d[1] = 24'h0A0B0C; exp_d[2] = 24'h102030; exp_d[3] = 24'h110033; exp_d[5] = 24'h00FFFF;
    for (int i = 0; i < 12; i++) begin
      rd_valid = 1'b1; rd_addr = i[3:0];
      tick();
      chk_d($sformatf("oor_keep_d%0d", i), if_d.rd_data_o, exp_d[i]);
    end
    idle();
    tick();

    // Reset while a read is in flight in both pipelines.
    rd_valid = 1'b1; rd_addr = 4'd1;
    tick();
    rd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_b("arst_vld_a", if_a.rd_valid_o, 1'b0);
    chk_d("arst_data_a", if_a.rd_data_o, 24'h0);
    chk_b("arst_vld_c", if_c.rd_valid_o, 1'b0);
    chk_d("arst_data_c", if_c.rd_data_o, 24'h0);
    chk_b("arst_busy_a", if_a.busy_o, 1'b1);
    chk_b("arst_busy_d", if_d.busy_o, 1'b1);
    repeat (2) tick();
    saw_vld = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      saw_vld = saw_vld | if_a.rd_valid_o | if_c.rd_valid_o;
    end
    chk_b("midclr_busy_a", if_a.busy_o, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_b("midclr_state_a", if_a.dbg_state, CLEAR);
    tick();
    @(negedge clk) reset_n = 1'b1;
    count_busy();
    chk_i("reclr_len_a", na, 16);
    chk_i("reclr_len_c", nc, 16);
    chk_i("reclr_len_d", nd, 12);
    chk_b("reclr_no_stale_vld", saw_vld, 1'b0);
    rd_valid = 1'b1; rd_addr = 4'd3;
    tick();
    rd_valid = 1'b0;
    chk_d("refill_a3", if_a.rd_data_o, 24'hA5A5A5);
    chk_d("refill_b3", if_b.rd_data_o, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
